uvmt_udma_rx_proto_chkr: RTL and testbench

// Parametrised multi-channel uDMA Rx protocol checker, bound next to the Rx channel DUT wrapper in the bench.
// Per channel: tracks the configured transfer, counts handshaken bytes, flags protocol violations as sticky

---
 rtl/uvmt_udma_rx_proto_chkr.sv | 233 +++++++++++++++++++++++
 tb/tb_uvmt_udma_rx_proto_chkr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_udma_rx_proto_chkr.sv
// uvmt_udma_rx_proto_chkr
// Multi-channel uDMA Rx data-plane protocol checker. Pure observer: tracks
// each configured transfer, counts handshaken bytes, records the first
// protocol violation as a sticky error code and pulses completion.
// Optional stall watchdog: define UVMT_UDMA_RX_PROTO_CHKR_TIMEOUT_EN.
`timescale 1ns/1ps

module uvmt_udma_rx_proto_chkr #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SIZE_W  = 20,
  parameter int unsigned TMO_CYC = 256
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_CH-1:0]          start_i,
  input  logic [N_CH*SIZE_W-1:0]   size_i,
  input  logic [N_CH*2-1:0]        datasize_i,
  input  logic [N_CH-1:0]          valid_i,
  input  logic [N_CH-1:0]          ready_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic [N_CH-1:0]          clr_i,
  output logic [N_CH-1:0]          busy_o,
  output logic [N_CH-1:0]          done_o,
  output logic [N_CH-1:0]          err_o,
  output logic [N_CH*3-1:0]        err_code_o,
  output logic [N_CH*SIZE_W-1:0]   remaining_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CODE_NONE       = 3'd0,
    CODE_DROP       = 3'd1,
    CODE_UNSTABLE   = 3'd2,
    CODE_OVERRUN    = 3'd3,
    CODE_BAD_DS     = 3'd4,
    CODE_TIMEOUT    = 3'd5,
    CODE_START_BUSY = 3'd6
  } code_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch

    // Per-channel views of the flattened buses
    logic              start;
    logic [SIZE_W-1:0] size;
    logic [1:0]        ds;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              clr;
    logic              hs;

    assign start = start_i[g];
    assign size  = size_i[g*SIZE_W +: SIZE_W];
    assign ds    = datasize_i[g*2 +: 2];
    assign valid = valid_i[g];
    assign ready = ready_i[g];
    assign data  = data_i[g*DATA_W +: DATA_W];
    assign clr   = clr_i[g];
    assign hs    = valid & ready;

    // Channel state
    state_t            state_q, state_d;
    logic [SIZE_W-1:0] rem_q, rem_d;
    logic [2:0]        beat_q, beat_d;
    code_t             code_q, code_d;
    logic              done_q, done_d;

    // Previous-cycle data-plane history for DROP / UNSTABLE detection
    logic              valid_prev_q;
    logic              hs_prev_q;
    logic              stall_prev_q;
    logic [DATA_W-1:0] data_prev_q;

    // Violation detectors
    logic              drop;
    logic              unstable;
    logic              overrun;
    logic              bad_ds;
    logic              timeout;
    logic              start_busy;
    logic              viol;
    code_t             viol_code;
    logic [SIZE_W-1:0] beat_ext;

    assign beat_ext = {{(SIZE_W-3){1'b0}}, beat_q};

    assign drop       = valid_prev_q & ~valid & ~hs_prev_q;
    assign unstable   = stall_prev_q & valid & (data != data_prev_q);
    assign overrun    = hs & ((state_q == ST_IDLE) ||
                              ((state_q == ST_ACTIVE) && (beat_ext > rem_q)));
    assign bad_ds     = start & (ds == 2'd3);
    assign start_busy = start & (state_q == ST_ACTIVE);

`ifdef UVMT_UDMA_RX_PROTO_CHKR_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: ACTIVE cycles with valid held and no ready
    always_comb begin
      stall_cnt_d = '0;
      timeout     = 1'b0;
      if ((state_q == ST_ACTIVE) && valid && !ready) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
        timeout     = (stall_cnt_d == TMO_W'(TMO_CYC));
      end
    end

    // Stall counter register
    always_ff @(posedge clk_i) begin
      if (!rstn_i) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Lowest code wins when several violations hit on the same edge
    always_comb begin
      viol      = 1'b1;
      viol_code = CODE_NONE;
      if      (drop)       viol_code = CODE_DROP;
      else if (unstable)   viol_code = CODE_UNSTABLE;
      else if (overrun)    viol_code = CODE_OVERRUN;
      else if (bad_ds)     viol_code = CODE_BAD_DS;
      else if (timeout)    viol_code = CODE_TIMEOUT;
      else if (start_busy) viol_code = CODE_START_BUSY;
      else                 viol      = 1'b0;
    end

    // Next-state and transfer bookkeeping; clr overrides every event
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      code_d  = code_q;
      done_d  = 1'b0;
      if (clr) begin
        state_d = ST_IDLE;
        rem_d   = '0;
        code_d  = CODE_NONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (viol) begin
              state_d = ST_ERR;
              code_d  = viol_code;
            end else if (start) begin
              if (size == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_ACTIVE;
                rem_d   = size;
                case (ds)
                  2'd0:    beat_d = 3'd1;
                  2'd1:    beat_d = 3'd2;
                  default: beat_d = 3'd4;
                endcase
              end
            end
          end
          ST_ACTIVE: begin
            if (viol) begin
              state_d = ST_ERR;
              code_d  = viol_code;
              // A restart abandons the in-flight transfer
              if (start_busy) rem_d = '0;
            end else if (hs) begin
              rem_d = rem_q - beat_ext;
              if (rem_d == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
          ST_ERR: begin
            // First error wins; hold until cleared
          end
          default: begin
            state_d = ST_IDLE;
            rem_d   = '0;
            code_d  = CODE_NONE;
          end
        endcase
      end
    end

    // Channel state registers
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        state_q <= ST_IDLE;
        rem_q   <= '0;
        beat_q  <= '0;
        code_q  <= CODE_NONE;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        beat_q  <= beat_d;
        code_q  <= code_d;
        done_q  <= done_d;
      end
    end

    // Data-plane history registers
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        valid_prev_q <= 1'b0;
        hs_prev_q    <= 1'b0;
        stall_prev_q <= 1'b0;
        data_prev_q  <= '0;
      end else begin
        valid_prev_q <= valid;
        hs_prev_q    <= hs;
        stall_prev_q <= valid & ~ready;
        data_prev_q  <= data;
      end
    end

    assign busy_o[g]                       = (state_q == ST_ACTIVE);
    assign done_o[g]                       = done_q;
    assign err_o[g]                        = (state_q == ST_ERR);
    assign err_code_o[g*3 +: 3]            = code_q;
    assign remaining_o[g*SIZE_W +: SIZE_W] = rem_q;
  end

endmodule

// File: tb/tb_uvmt_udma_rx_proto_chkr.sv
// Directed self-checking bench for uvmt_udma_rx_proto_chkr.
// Honours UVMT_UDMA_RX_PROTO_CHKR_TIMEOUT_EN for the watchdog scenario.
`timescale 1ns/1ps

module tb_uvmt_udma_rx_proto_chkr;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 20;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [N_CH-1:0]        start;
  logic [N_CH*SIZE_W-1:0] size;
  logic [N_CH*2-1:0]      datasize;
  logic [N_CH-1:0]        valid;
  logic [N_CH-1:0]        ready;
  logic [N_CH*DATA_W-1:0] data;
  logic [N_CH-1:0]        clr;
  logic [N_CH-1:0]        busy;
  logic [N_CH-1:0]        done;
  logic [N_CH-1:0]        err;
  logic [N_CH*3-1:0]      err_code;
  logic [N_CH*SIZE_W-1:0] remaining;

  int tests = 0;
  int fails = 0;

  uvmt_udma_rx_proto_chkr #(
    .N_CH(N_CH), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TMO_CYC(256)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .size_i(size),
    .datasize_i(datasize), .valid_i(valid), .ready_i(ready), .data_i(data),
    .clr_i(clr), .busy_o(busy), .done_o(done), .err_o(err),
    .err_code_o(err_code), .remaining_o(remaining)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE_W-1:0] rem(input int ch);
    return remaining[ch*SIZE_W +: SIZE_W];
  endfunction

  function automatic logic [2:0] code(input int ch);
    return err_code[ch*3 +: 3];
  endfunction

  initial begin
    rstn = 1'b0; start = '0; size = '0; datasize = '0;
    valid = '0; ready = '0; data = '0; clr = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_rem", remaining, 0);
    rstn = 1'b1;
    step();

    // ch0: size 8, 4-byte beats, two clean beats
    start[0] = 1'b1; size[0*SIZE_W +: SIZE_W] = 20'd8; datasize[0*2 +: 2] = 2'd2;
    step();
    start[0] = 1'b0;
    chk("ch0_busy_start", busy, 4'b0001);
    chk("ch0_rem8", rem(0), 8);
    valid[0] = 1'b1; ready[0] = 1'b1;
    step();
    chk("ch0_rem4", rem(0), 4);
    chk("ch0_no_done_mid", done, 0);
    step();
    chk("ch0_rem0", rem(0), 0);
    chk("ch0_done", done, 4'b0001);
    chk("ch0_busy_low", busy, 0);
    valid[0] = 1'b0; ready[0] = 1'b0;
    step();
    chk("ch0_done_1cyc", done, 0);
    chk("ch0_no_err", err, 0);

    // ch1: size 6, 4-byte beats, second beat overruns
    start[1] = 1'b1; size[1*SIZE_W +: SIZE_W] = 20'd6; datasize[1*2 +: 2] = 2'd2;
    step();
    start[1] = 1'b0;
    chk("ch1_rem6", rem(1), 6);
    valid[1] = 1'b1; ready[1] = 1'b1;
    step();
    chk("ch1_rem2", rem(1), 2);
    step();
    valid[1] = 1'b0; ready[1] = 1'b0;
    chk("ch1_err", err, 4'b0010);
    chk("ch1_code3", code(1), 3);
    chk("ch1_rem_hold", rem(1), 2);
    chk("ch1_no_done", done, 0);

    // ch2: data changes while stalled
    valid[2] = 1'b1; data[2*DATA_W +: DATA_W] = 32'hA5A5A5A5;
    step();
    chk("ch2_stall_ok", err[2], 0);
    data[2*DATA_W +: DATA_W] = 32'h5A5A5A5A;
    step();
    chk("ch2_err", err[2], 1);
    chk("ch2_code2", code(2), 2);
    clr[2] = 1'b1; valid[2] = 1'b0;
    step();
    clr[2] = 1'b0;
    chk("ch2_clr_err", err[2], 0);
    chk("ch2_clr_code", code(2), 0);
    chk("ch2_clr_busy", busy[2], 0);
    step();
    chk("ch2_stays_clean", err[2], 0);

    // ch0 DROP together with ch3 illegal datasize
    valid[0] = 1'b1; ready[0] = 1'b0;
    step();
    chk("ch0_pre_drop", err[0], 0);
    valid[0] = 1'b0;
    start[3] = 1'b1; size[3*SIZE_W +: SIZE_W] = 20'd16; datasize[3*2 +: 2] = 2'd3;
    step();
    start[3] = 1'b0; datasize[3*2 +: 2] = 2'd0;
    chk("multi_err", err, 4'b1011);
    chk("multi_code", err_code, {3'd4, 3'd0, 3'd3, 3'd1});
    chk("multi_rem", remaining, {20'd0, 20'd0, 20'd2, 20'd0});
    chk("multi_busy", busy, 0);
    clr = '1;
    step();
    clr = '0;
    chk("clr_all_err", err, 0);
    chk("clr_all_code", err_code, 0);
    chk("clr_all_rem", remaining, 0);

    // ch1: zero-size start completes immediately
    start[1] = 1'b1; size[1*SIZE_W +: SIZE_W] = 20'd0; datasize[1*2 +: 2] = 2'd0;
    step();
    start[1] = 1'b0;
    chk("zero_done", done, 4'b0010);
    chk("zero_busy", busy, 0);
    chk("zero_err", err, 0);
    step();
    chk("zero_done_1cyc", done, 0);

    // ch2: restart while active
    start[2] = 1'b1; size[2*SIZE_W +: SIZE_W] = 20'd16; datasize[2*2 +: 2] = 2'd0;
    step();
    chk("sb_busy", busy, 4'b0100);
    chk("sb_rem16", rem(2), 16);
    step();
    start[2] = 1'b0;
    chk("sb_err", err, 4'b0100);
    chk("sb_code6", code(2), 6);
    chk("sb_busy_low", busy, 0);
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    chk("sb_clr", err, 0);

    // ch0: stall watchdog
    start[0] = 1'b1; size[0*SIZE_W +: SIZE_W] = 20'd4; datasize[0*2 +: 2] = 2'd0;
    step();
    start[0] = 1'b0;
    valid[0] = 1'b1; ready[0] = 1'b0; data[0*DATA_W +: DATA_W] = 32'h1234_5678;
`ifdef UVMT_UDMA_RX_PROTO_CHKR_TIMEOUT_EN
    repeat (255) step();
    chk("tmo_255_clean", err[0], 0);
    chk("tmo_255_busy", busy[0], 1);
    step();
    chk("tmo_err", err[0], 1);
    chk("tmo_code5", code(0), 5);
`else
    repeat (1000) step();
    chk("notmo_err", err, 0);
    chk("notmo_busy", busy, 4'b0001);
    chk("notmo_rem", rem(0), 4);
`endif
    valid[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("tmo_clr", err, 0);

    // ch3: reset mid-transfer
    start[3] = 1'b1; size[3*SIZE_W +: SIZE_W] = 20'd12; datasize[3*2 +: 2] = 2'd0;
    step();
    start[3] = 1'b0;
    chk("mid_rem12", rem(3), 12);
    chk("mid_busy", busy, 4'b1000);
    rstn = 1'b0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_rem", remaining, 0);
    rstn = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
